bram_pixel_reader: RTL and testbench
====================================

// Module: bram_pixel_reader
// PURPOSE
//  Read controller for BRAM port B in the image pipeline. Given a base address and a
//  word count, issues reads (addrb/enb) and prefetches up to 2 words. Unpacks each
//  32-bit doutb word into four 8-bit pixels, LSB byte first, and emits them on a
//  valid/ready pixel stream. Sits between frame-buffer BRAM and the byte-wise filters.
// PARAMETERS
//  ADDR_W   16  BRAM word-address width; also width of num_words
//  RD_LAT   1   BRAM read latency in cycles, enb to doutb valid; legal values 1 or 2
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       one-cycle command pulse; ignored while busy=1
//  base_addr  in   ADDR_W  first word address, sampled with start
//  num_words  in   ADDR_W  number of words to read, sampled with start
//  busy       out  1       transfer in progress
//  done       out  1       one-cycle pulse at transfer completion
//  addrb      out  ADDR_W  BRAM port-B address
//  enb        out  1       BRAM port-B read enable, one cycle per word
//  doutb      in   32      BRAM port-B read data, valid RD_LAT cycles after enb
//  pix        out  8       pixel byte
//  pix_valid  out  1       pix is valid
//  pix_ready  in   1       downstream accepts pix this cycle
//  pix_last   out  1       marks the final byte of the transfer
// BEHAVIOUR
//  - Reset: busy, done, enb, pix_valid and pix_last are 0; addrb and pix are 0.
//    All counters and the buffer are cleared; tags of in-flight reads are discarded.
//  - Command, start sampled at cycle 0 with busy=0:
//    - base_addr and num_words are latched.
//    - num_words=0: done=1 at cycle 1; busy stays 0; no reads are issued.
//    - Otherwise busy=1 from cycle 1.
//  - FSM states: IDLE, RUN, DRAIN.
//    - IDLE->RUN on an accepted start with num_words!=0.
//    - RUN->DRAIN when the last read has been issued.
//    - DRAIN->IDLE on the handshake of the last byte.
//  - Read issue (credit rule): enb=1 in a cycle only if reads remain and
//    outstanding_reads + buffered_words < 2.
//    - addrb = current address; the address then increments and wraps modulo 2^ADDR_W.
//    - The first enb is at cycle 1, with addrb=base_addr.
//  - Data capture: a RD_LAT-deep valid-tag shift register marks returning doutb.
//    The returning word is written into a 2-entry word FIFO; overflow cannot occur
//    under the credit rule.
//  - Emission: pix = byte[k] of the FIFO head word.
//    - k=0 is [7:0], k=1 is [15:8], k=2 is [23:16], k=3 is [31:24].
//    - A handshake is pix_valid & pix_ready; it advances k.
//    - After k=3 the FIFO is popped and k returns to 0.
//    - pix_valid, pix and pix_last hold steady while pix_ready=0.
//  - Latency: first pix_valid=1 at cycle 2+RD_LAT.
//    With pix_ready held at 1, throughput is 1 byte/cycle with no bubbles.
//  - pix_last=1 only with byte 3 of word num_words-1.
//  - Completion: on the handshake of the last byte, done=1 and busy=0 in the next
//    cycle, simultaneously. A start arriving in that same cycle is accepted, since
//    busy=0 then.
//  - pix_ready=0 for any duration: reads stall by credit; nothing is lost or duplicated.
//  - A start while busy=1 has no effect, including its latched inputs.
// STRUCTURE
//  - Package bram_rd_pkg: BYTES_PER_WORD=4; state enum {IDLE, RUN, DRAIN}.
//  - Sub-module word_fifo2: 2-entry 32-bit FIFO with push, pop, count[1:0], head.
//  - Top level: FSM, address and word counters, tag shift register, byte index.
// TESTING
//  - base=0x0010, num_words=3, pix_ready=1, BRAM[0x10..0x12]=0x44332211,0x88776655,0xCCBBAA99
//    -> pix sequence 11..CC; pix_last only on CC; done one cycle after the CC handshake.
//  - num_words=0 -> done pulse at cycle 1; busy, enb and pix_valid stay 0.
//  - Run 1 with RD_LAT=2 -> first pix_valid at cycle 4; byte order and count match run 1.
//  - pix_ready toggling 1,0,0,1 repeating -> no dropped or duplicated bytes;
//    outstanding reads + buffered words never exceed 2.
//  - base=0xFFFF, num_words=2, ADDR_W=16 -> addrb issues 0xFFFF then 0x0000.
//  - rst_n low for 1 cycle while 1 word is in flight -> all outputs 0;
//    a new start reads from its own base with no stale data.
//  - start pulsed again while busy -> ignored; byte count equals 4*num_words of the first command.

Source files
------------

// File: rtl/bram_rd_pkg.sv
// Shared definitions for the BRAM pixel reader.
//   BYTES_PER_WORD : pixels unpacked from each 32-bit BRAM word
//   rd_state_e     : controller states (IDLE, RUN, DRAIN)
package bram_rd_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry 32-bit word FIFO holding BRAM words awaiting unpacking.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write din_i this cycle (caller guarantees not full)
//   din_i      : word to write
//   pop_i      : drop the head word this cycle (caller guarantees not empty)
//   count_o    : number of stored words (0..2)
//   head_o     : oldest stored word
module word_fifo2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic [31:0] din_i,
    input  logic        pop_i,
    output logic [1:0]  count_o,
    output logic [31:0] head_o
);

    logic [31:0] mem_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/bram_pixel_reader.sv
// BRAM port-B read controller for the image pipeline. Reads num_words words
// starting at base_addr, keeps at most two words in flight or buffered, and
// streams each word out as four bytes (LSB byte first) on a valid/ready port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : command pulse, ignored while busy
//   base_addr, num_words: command operands, sampled with start
//   busy, done          : transfer in progress / one-cycle completion pulse
//   addrb, enb, doutb   : BRAM port B (doutb valid RD_LAT cycles after enb)
//   pix, pix_valid,
//   pix_ready, pix_last : byte stream; pix_last marks the final byte
module bram_pixel_reader
    import bram_rd_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addrb,
    output logic              enb,
    input  logic [31:0]       doutb,
    output logic [7:0]        pix,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic              done_q, done_d;
    logic [RD_LAT-1:0] tag_q, tag_d;

    logic [1:0]  out_cnt;
    logic [1:0]  fifo_cnt;
    logic [31:0] fifo_head;
    logic        credit_ok;
    logic        hs;
    logic        pop;
    logic        last_word;

    // Tag bit i set means a read issued i+1 cycles ago is still returning;
    // the oldest tag lines up with valid doutb.
    if (RD_LAT == 1) begin : g_tag1
        assign tag_d = enb;
    end else begin : g_tagn
        assign tag_d = {tag_q[RD_LAT-2:0], enb};
    end

    always_comb begin
        out_cnt = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            out_cnt = out_cnt + {1'b0, tag_q[i]};
        end
    end

    word_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tag_q[RD_LAT-1]),
        .din_i   (doutb),
        .pop_i   (pop),
        .count_o (fifo_cnt),
        .head_o  (fifo_head)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        done_d     = 1'b0;

        busy      = (state_q != IDLE);
        done      = done_q;
        addrb     = addr_q;
        credit_ok = (({1'b0, out_cnt} + {1'b0, fifo_cnt}) < 3'd2);
        enb       = (state_q == RUN) && (remain_q != '0) && credit_ok;
        pix_valid = (fifo_cnt != 2'd0);
        hs        = pix_valid && pix_ready;
        pop       = hs && (byte_idx_q == LAST_IDX);
        // Once every read is issued and returned, a lone buffered word is
        // necessarily the final word of the transfer.
        last_word = (state_q == DRAIN) && (out_cnt == 2'd0) && (fifo_cnt == 2'd1);
        pix_last  = pix_valid && (byte_idx_q == LAST_IDX) && last_word;
        byte_idx_d = hs ? byte_idx_q + 2'd1 : byte_idx_q;

        case (byte_idx_q)
            2'd0:    pix = fifo_head[7:0];
            2'd1:    pix = fifo_head[15:8];
            2'd2:    pix = fifo_head[23:16];
            default: pix = fifo_head[31:24];
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        state_d  = RUN;
                        addr_d   = base_addr;
                        remain_d = num_words;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (enb) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == ADDR_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (hs && pix_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            byte_idx_q <= '0;
            done_q     <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            byte_idx_q <= byte_idx_d;
            done_q     <= done_d;
            tag_q      <= tag_d;
        end
    end

endmodule

// File: tb/tb_bram_pixel_reader.sv
// Bench for bram_pixel_reader: two instances (RD_LAT=1 and RD_LAT=2) share
// command/ready stimulus; each has its own BRAM model and stream monitor.
module tb_bram_pixel_reader;

    typedef struct {
        logic [15:0] base;
        logic [15:0] num;
        int          mode;
        int          exp_bytes;
        logic [15:0] exp_end;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] num_words;
    logic        pix_ready;

    logic        busy_s [2];
    logic        done_s [2];
    logic        enb_s [2];
    logic        pix_valid_s [2];
    logic        pix_last_s [2];
    logic [15:0] addrb_s [2];
    logic [7:0]  pix_s [2];
    logic [31:0] doutb_s [2];
    logic [31:0] stage1;

    logic [31:0] mem [0:65535];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int ready_mode = 0;
    bit mon_clr = 1'b1;

    int          n_bytes [2], n_last [2], last_pos [2], n_done [2], done_rel [2];
    int          last_hs_rel [2], n_issued [2], n_popped [2], first_enb_rel [2];
    int          first_valid_rel [2], max_inflight [2], hold_viol [2];
    logic [15:0] first_addr [2], last_addr [2];
    bit          busy_seen [2];
    logic [7:0]  got_pix [2][64];
    bit          prev_stall [2];
    logic [7:0]  prev_pix [2];
    logic        prev_last [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        bram_pixel_reader #(.ADDR_W(16), .RD_LAT(gi + 1)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .base_addr (base_addr),
            .num_words (num_words),
            .busy      (busy_s[gi]),
            .done      (done_s[gi]),
            .addrb     (addrb_s[gi]),
            .enb       (enb_s[gi]),
            .doutb     (doutb_s[gi]),
            .pix       (pix_s[gi]),
            .pix_valid (pix_valid_s[gi]),
            .pix_ready (pix_ready),
            .pix_last  (pix_last_s[gi])
        );
    end

    // BRAM models; non-read cycles return a marker word.
    always @(posedge clk) begin
        doutb_s[0] <= enb_s[0] ? mem[addrb_s[0]] : 32'hDEADBEEF;
        stage1     <= enb_s[1] ? mem[addrb_s[1]] : 32'hDEADBEEF;
        doutb_s[1] <= stage1;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : ready_driver
        int rcnt;
        rcnt = 0;
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            case (ready_mode)
                1:       pix_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
                2:       pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = 1'b1;
            endcase
        end
    end

    initial forever begin : monitor
        int rel, infl;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (mon_clr) begin
                n_bytes[d] = 0; n_last[d] = 0; last_pos[d] = -1; n_done[d] = 0;
                done_rel[d] = -1; last_hs_rel[d] = -1; n_issued[d] = 0; n_popped[d] = 0;
                first_enb_rel[d] = -1; first_valid_rel[d] = -1; max_inflight[d] = 0;
                hold_viol[d] = 0; busy_seen[d] = 1'b0; prev_stall[d] = 1'b0;
                first_addr[d] = '0; last_addr[d] = '0;
            end else begin
                rel = cyc - start_cyc;
                if (busy_s[d]) busy_seen[d] = 1'b1;
                if (enb_s[d]) begin
                    if (n_issued[d] == 0) begin
                        first_enb_rel[d] = rel;
                        first_addr[d]    = addrb_s[d];
                    end
                    last_addr[d] = addrb_s[d];
                    n_issued[d]++;
                end
                infl = n_issued[d] - n_popped[d];
                if (infl > max_inflight[d]) max_inflight[d] = infl;
                if (prev_stall[d] && (!pix_valid_s[d] || pix_s[d] != prev_pix[d]
                                      || pix_last_s[d] != prev_last[d]))
                    hold_viol[d]++;
                if (pix_valid_s[d] && first_valid_rel[d] < 0) first_valid_rel[d] = rel;
                if (pix_valid_s[d] && pix_ready) begin
                    if (n_bytes[d] < 64) got_pix[d][n_bytes[d]] = pix_s[d];
                    if (pix_last_s[d]) begin
                        n_last[d]++;
                        last_pos[d] = n_bytes[d];
                    end
                    if ((n_bytes[d] % 4) == 3) n_popped[d]++;
                    last_hs_rel[d] = rel;
                    n_bytes[d]++;
                end
                if (done_s[d]) begin
                    n_done[d]++;
                    done_rel[d] = rel;
                end
                prev_stall[d] = pix_valid_s[d] && !pix_ready;
                prev_pix[d]   = pix_s[d];
                prev_last[d]  = pix_last_s[d];
            end
        end
    end

    task automatic check(input string name, input int d, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s [dut RD_LAT=%0d]: got 0x%0h, expected 0x%0h", name, d + 1, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string name);
        for (int d = 0; d < 2; d++) begin
            check({name, "_ctrl"}, d,
                  {busy_s[d], done_s[d], enb_s[d], pix_valid_s[d], pix_last_s[d]}, 0);
            check({name, "_addrb"}, d, addrb_s[d], 0);
            check({name, "_pix"}, d, pix_s[d], 0);
        end
    endtask

    task automatic clear_monitor();
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic check_results(input logic [15:0] base, input logic [15:0] num,
                                 input int mode, input int exp_bytes, input logic [15:0] exp_end);
        for (int d = 0; d < 2; d++) begin
            check("byte_count", d, n_bytes[d], exp_bytes);
            check("reads_issued", d, n_issued[d], num);
            check("done_count", d, n_done[d], 1);
            check("inflight_le_2", d, max_inflight[d] <= 2, 1);
            check("stall_hold", d, hold_viol[d], 0);
            if (num == 16'd0) begin
                check("zero_done_cycle", d, done_rel[d], 1);
                check("zero_busy_seen", d, busy_seen[d], 0);
                check("zero_valid_cycle", d, first_valid_rel[d], -1);
            end else begin
                int mism;
                mism = 0;
                for (int j = 0; j < n_bytes[d] && j < exp_bytes && j < 64; j++) begin
                    logic [15:0] a;
                    logic [31:0] w;
                    a = base + 16'(j / 4);
                    w = mem[a];
                    if (got_pix[d][j] != 8'(w >> (8 * (j % 4)))) mism++;
                end
                check("byte_data_mismatches", d, mism, 0);
                check("last_count", d, n_last[d], 1);
                check("last_position", d, last_pos[d], exp_bytes - 1);
                check("done_after_last", d, done_rel[d], last_hs_rel[d] + 1);
                check("first_enb_cycle", d, first_enb_rel[d], 1);
                check("first_addrb", d, first_addr[d], base);
                check("final_addrb", d, last_addr[d], exp_end);
                check("first_valid_cycle", d, first_valid_rel[d], 3 + d);
                if (mode == 0)
                    check("no_bubbles", d, last_hs_rel[d] - first_valid_rel[d], exp_bytes - 1);
            end
        end
    endtask

    task automatic run_txn(input logic [15:0] base, input logic [15:0] num, input int mode,
                           input int exp_bytes, input logic [15:0] exp_end, input bit dbl_start);
        int waited;
        ready_mode = mode;
        clear_monitor();
        base_addr = base;
        num_words = num;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = 16'hA5A5;
        num_words = 16'h00FF;
        waited = 0;
        while ((n_done[0] == 0 || n_done[1] == 0) && waited < 3000) begin
            if (dbl_start && waited == 1) begin
                start     = 1'b1;
                base_addr = 16'h0200;
                num_words = 16'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            waited++;
        end
        start = 1'b0;
        check("done_within_budget", 0, waited < 3000, 1);
        repeat (10) @(posedge clk);
        #1;
        check_results(base, num, mode, exp_bytes, exp_end);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [6];
        tbl[0] = '{base: 16'h0010, num: 16'd3, mode: 0, exp_bytes: 12, exp_end: 16'h0012};
        tbl[1] = '{base: 16'h0100, num: 16'd5, mode: 1, exp_bytes: 20, exp_end: 16'h0104};
        tbl[2] = '{base: 16'hFFFF, num: 16'd2, mode: 0, exp_bytes: 8,  exp_end: 16'h0000};
        tbl[3] = '{base: 16'h1234, num: 16'd6, mode: 2, exp_bytes: 24, exp_end: 16'h1239};
        tbl[4] = '{base: 16'h0020, num: 16'd1, mode: 1, exp_bytes: 4,  exp_end: 16'h0020};
        tbl[5] = '{base: 16'h0300, num: 16'd0, mode: 0, exp_bytes: 0,  exp_end: 16'h0000};

        for (int a = 0; a < 65536; a++) begin
            mem[a] = (32'(a) * 32'h9E3779B1) ^ 32'hA5A5A5A5;
        end
        mem[16'h0010] = 32'h44332211;
        mem[16'h0011] = 32'h88776655;
        mem[16'h0012] = 32'hCCBBAA99;

        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_words = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i].base, tbl[i].num, tbl[i].mode, tbl[i].exp_bytes, tbl[i].exp_end, 1'b0);
            if (i == 0) begin
                for (int d = 0; d < 2; d++) begin
                    check("run1_byte0", d, got_pix[d][0], 8'h11);
                    check("run1_byte4", d, got_pix[d][4], 8'h55);
                    check("run1_byte11", d, got_pix[d][11], 8'hCC);
                end
            end
        end

        // start pulsed again while busy must be ignored
        run_txn(16'h0040, 16'd4, 1, 16, 16'h0043, 1'b1);

        // reset while the first word is in flight, then a fresh transfer
        ready_mode = 0;
        clear_monitor();
        base_addr = 16'h0060;
        num_words = 16'd4;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outs("midflight_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_txn(16'h0050, 16'd2, 0, 8, 16'h0051, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
